// File: rtl/cliff_game_core.sv
// Game core for the "walk the group off the cliff" LED game.
// Holds the FSM, group position, step timer, lives, score and the LED bar composition.
module cliff_game_core #(
    parameter int WIDTH      = 16,
    parameter int GROUP      = 3,
    parameter int START_IDX  = 7,
    parameter int NUM_SPEEDS = 4,
    parameter int BASE_DIV   = 50000000,
    parameter int BLINK_DIV  = 5000000,
    parameter int LIVES      = 3,
    localparam int PW = $clog2(WIDTH),
    localparam int SW = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             left,
    input  logic             right,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic [PW-1:0]    left_margin,
    input  logic [PW-1:0]    right_margin,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       state,
    output logic [PW-1:0]    pos,
    output logic [1:0]       dir,
    output logic [SW-1:0]    speed,
    output logic [LW-1:0]    lives,
    output logic [15:0]      score
);
    localparam int HALF = (GROUP - 1) / 2;
    localparam int P1   = PW + 1;
    localparam int CW   = $clog2(BASE_DIV + 1);
    localparam int BW   = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d, lm_q, lm_d, rm_q, rm_d;
    logic [1:0]      dir_q, dir_d;
    logic [SW-1:0]   speed_q, speed_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [15:0]     score_q, score_d;
    logic [CW-1:0]   step_cnt_q, step_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic            step_s, hit_s;
    logic [P1-1:0]   pos_x_s, lm_x_s, rm_x_s;
    logic [PW-1:0]   ml_s, mr_s;
    logic [WIDTH-1:0] group_s, wall_s;

    function automatic logic [CW-1:0] reload_val(input logic [SW-1:0] spd);
        return CW'((BASE_DIV >> spd) - 1);
    endfunction

    assign pos_x_s = {1'b0, pos_q};
    assign lm_x_s  = {1'b0, lm_q};
    assign rm_x_s  = {1'b0, rm_q};
    assign step_s  = (state_q == ST_RUN) && (step_cnt_q == CW'(0));
    // Wall contact is judged on the registered position, so it lands one cycle after the move.
    assign hit_s   = ((pos_x_s + P1'(HALF)) >= (P1'(WIDTH - 1) - lm_x_s)) ||
                     (pos_x_s <= (rm_x_s + P1'(HALF)));

    // Next-state logic for the game FSM and its datapath.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        speed_d     = speed_q;
        lives_d     = lives_q;
        score_d     = score_q;
        lm_d        = lm_q;
        rm_d        = rm_q;
        step_cnt_d  = step_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        if ((state_q != ST_LOSE) && (speed_up != speed_down)) begin
            if (speed_up) begin
                if (speed_q != SW'(NUM_SPEEDS - 1)) speed_d = speed_q + SW'(1);
                else                                speed_d = speed_q;
            end else begin
                if (speed_q != SW'(0)) speed_d = speed_q - SW'(1);
                else                   speed_d = speed_q;
            end
        end else begin
            speed_d = speed_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (left && !right && ((pos_x_s + P1'(HALF + 1)) <= P1'(WIDTH - 2))) begin
                    pos_d = pos_q + PW'(1);
                end else if (right && !left && (pos_x_s >= P1'(HALF + 2))) begin
                    pos_d = pos_q - PW'(1);
                end else begin
                    pos_d = pos_q;
                end
                if (start) begin
                    state_d    = ST_RUN;
                    lm_d       = left_margin;
                    rm_d       = right_margin;
                    dir_d      = 2'd0;
                    score_d    = 16'd0;
                    lives_d    = LW'(LIVES);
                    step_cnt_d = reload_val(speed_q);
                end else begin
                    step_cnt_d = CW'(0);
                end
            end
            ST_RUN: begin
                if (step_s) step_cnt_d = reload_val(speed_q);
                else        step_cnt_d = step_cnt_q - CW'(1);
                if (start) begin
                    state_d    = ST_IDLE;
                    pos_d      = PW'(START_IDX);
                    dir_d      = 2'd0;
                    step_cnt_d = CW'(0);
                end else if (hit_s) begin
                    dir_d = 2'd0;
                    if (lives_q > LW'(1)) begin
                        lives_d = lives_q - LW'(1);
                        pos_d   = PW'(START_IDX);
                    end else begin
                        lives_d     = LW'(0);
                        state_d     = ST_LOSE;
                        step_cnt_d  = CW'(0);
                        blink_cnt_d = BW'(0);
                        blink_d     = 1'b1;
                    end
                end else begin
                    if (left && !right)      dir_d = 2'd1;
                    else if (right && !left) dir_d = 2'd2;
                    else                     dir_d = dir_q;
                    if (step_s && (dir_q != 2'd0)) begin
                        if (dir_q == 2'd1) pos_d = pos_q + PW'(1);
                        else               pos_d = pos_q - PW'(1);
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                        else                     score_d = score_q;
                    end else begin
                        pos_d = pos_q;
                    end
                end
            end
            ST_LOSE: begin
                if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                    blink_cnt_d = BW'(0);
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
                if (start) begin
                    state_d     = ST_IDLE;
                    pos_d       = PW'(START_IDX);
                    lives_d     = LW'(LIVES);
                    score_d     = 16'd0;
                    blink_cnt_d = BW'(0);
                    blink_d     = 1'b0;
                end else begin
                    state_d = ST_LOSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= PW'(START_IDX);
            dir_q       <= 2'd0;
            speed_q     <= SW'(0);
            lives_q     <= LW'(LIVES);
            score_q     <= 16'd0;
            lm_q        <= PW'(0);
            rm_q        <= PW'(0);
            step_cnt_q  <= CW'(0);
            blink_cnt_q <= BW'(0);
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            speed_q     <= speed_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            lm_q        <= lm_d;
            rm_q        <= rm_d;
            step_cnt_q  <= step_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // LED composition: group and wall masks, walls follow the live margins while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            ml_s = left_margin;
            mr_s = right_margin;
        end else begin
            ml_s = lm_q;
            mr_s = rm_q;
        end
        for (int i = 0; i < WIDTH; i++) begin
            group_s[i] = ((i + HALF) >= int'(pos_q)) && (i <= (int'(pos_q) + HALF));
            wall_s[i]  = (i == (WIDTH - 1 - int'(ml_s))) || (i == int'(mr_s));
        end
        case (state_q)
            ST_IDLE: led = group_s | wall_s;
            ST_RUN:  led = group_s;
            ST_LOSE: led = {WIDTH{blink_q}};
            default: led = {WIDTH{1'b0}};
        endcase
    end

    assign state = state_q;
    assign pos   = pos_q;
    assign dir   = dir_q;
    assign speed = speed_q;
    assign lives = lives_q;
    assign score = score_q;
endmodule

// File: tb/tb_cliff_game_core.sv
// Bench for cliff_game_core: directed scenarios plus random play against a timeline-based game model.
module tb_cliff_game_core;
    localparam int W = 16, G = 3, SI = 7, NS = 4, BD = 8, BK = 4, L = 2;
    localparam int HALF = (G - 1) / 2;

    logic clk = 1'b0, reset_n = 1'b0;
    logic start = 1'b0, left = 1'b0, right = 1'b0, su = 1'b0, sd = 1'b0;
    logic [3:0] lm_in = 4'd0, rm_in = 4'd0;
    logic [15:0] led, score;
    logic [1:0]  state, dir, speed, lives;
    logic [3:0]  pos;

    int total = 0, bad = 0;
    int m_state, m_pos, m_dir, m_speed, m_lives, m_score, m_lm, m_rm, m_next, m_lose_t, cyc = 0;

    cliff_game_core #(.WIDTH(W), .GROUP(G), .START_IDX(SI), .NUM_SPEEDS(NS),
                      .BASE_DIV(BD), .BLINK_DIV(BK), .LIVES(L)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .left(left), .right(right),
        .speed_up(su), .speed_down(sd), .left_margin(lm_in), .right_margin(rm_in),
        .led(led), .state(state), .pos(pos), .dir(dir), .speed(speed),
        .lives(lives), .score(score));

    always #5 clk = ~clk;

    function automatic logic [15:0] model_led();
        logic [15:0] v = 16'd0;
        for (int i = 0; i < W; i++) begin
            if (m_state != 2 && i >= m_pos - HALF && i <= m_pos + HALF) v[i] = 1'b1;
            if (m_state == 0 && (i == W - 1 - int'(lm_in) || i == int'(rm_in))) v[i] = 1'b1;
        end
        if (m_state == 2) v = ((((cyc - m_lose_t) / BK) % 2) == 0) ? 16'hFFFF : 16'h0000;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = SI; m_dir = 0; m_speed = 0; m_lives = L; m_score = 0;
        m_lm = 0; m_rm = 0; m_next = 0; m_lose_t = 0;
    endtask

    // Game rules at cycle granularity; steps are scheduled as absolute cycle numbers.
    task automatic model_clk(input bit st, input bit l, input bit r, input bit u, input bit d);
        int ns = m_state, np = m_pos, nd = m_dir, nsp = m_speed, nl = m_lives, nsc = m_score;
        bit step = (m_state == 1) && (cyc == m_next);
        bit hit = (m_pos + HALF >= W - 1 - m_lm) || (m_pos <= m_rm + HALF);
        if (m_state != 2 && u != d)
            nsp = u ? ((m_speed < NS - 1) ? m_speed + 1 : m_speed) : ((m_speed > 0) ? m_speed - 1 : 0);
        if (m_state == 0) begin
            if (l && !r && m_pos + HALF + 1 <= W - 2) np = m_pos + 1;
            else if (r && !l && m_pos - HALF - 1 >= 1) np = m_pos - 1;
            if (st) begin
                ns = 1; m_lm = int'(lm_in); m_rm = int'(rm_in); nd = 0; nsc = 0; nl = L;
                m_next = cyc + (BD >> m_speed);
            end
        end else if (m_state == 1) begin
            if (step) m_next = cyc + (BD >> m_speed);
            if (st) begin
                ns = 0; np = SI; nd = 0;
            end else if (hit) begin
                nd = 0;
                if (m_lives > 1) begin nl = m_lives - 1; np = SI; end
                else begin nl = 0; ns = 2; m_lose_t = cyc + 1; end
            end else begin
                if (l && !r) nd = 1; else if (r && !l) nd = 2;
                if (step && m_dir != 0) begin
                    np = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
                    if (m_score < 65535) nsc = m_score + 1;
                end
            end
        end else if (st) begin
            ns = 0; np = SI; nl = L; nsc = 0;
        end
        m_state = ns; m_pos = np; m_dir = nd; m_speed = nsp; m_lives = nl; m_score = nsc;
        cyc++;
    endtask

    task automatic drive(input bit st, input bit l, input bit r, input bit u, input bit d);
        @(negedge clk);
        start = st; left = l; right = r; su = u; sd = d;
        model_clk(st, l, r, u, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; lm_in = 4'd0; rm_in = 4'd0; model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1; #1;
        total++;
        if (led !== 16'h81C1) begin bad++; $display("FAIL reset_led got=%h exp=81c1", led); end
        total++;
        if ({state, pos, dir, speed, lives, score} !== {2'd0, 4'd7, 2'd0, 2'd0, 2'd2, 16'd0}) begin
            bad++; $display("FAIL reset_regs got st=%0d pos=%0d dir=%0d spd=%0d lives=%0d score=%0d exp 0/7/0/0/2/0",
                            state, pos, dir, speed, lives, score);
        end
    endtask

    task automatic test_idle_move();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, 0);
            total++;
            if (pos !== 4'(m_pos)) begin bad++; $display("FAIL idle_left got=%0d exp=%0d", pos, m_pos); end
        end
        total++;
        if ({pos, led} !== {4'd13, 16'hF001}) begin
            bad++; $display("FAIL idle_sat got pos=%0d led=%h exp pos=13 led=f001", pos, led);
        end
        drive(0, 1, 1, 0, 0);
        total++;
        if (pos !== 4'd13) begin bad++; $display("FAIL idle_both got=%0d exp=13", pos); end
        repeat (6) drive(0, 0, 1, 0, 0);
        total++;
        if (pos !== 4'd7) begin bad++; $display("FAIL idle_right got=%0d exp=7", pos); end
    endtask

    task automatic test_walk();
        int n = 0, maxp = 0;
        lm_in = 4'd2; rm_in = 4'd0;
        drive(1, 0, 0, 0, 0);
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL walk_start got=%0d exp=1", state); end
        drive(0, 1, 0, 0, 0);
        while (lives == 2'd2 && n < 200) begin
            drive(0, 0, 0, 0, 0);
            n++;
            if (int'(pos) > maxp && lives == 2'd2) maxp = int'(pos);
            total++;
            if ({pos, score} !== {4'(m_pos), 16'(m_score)}) begin
                bad++; $display("FAIL walk_track got pos=%0d score=%0d exp pos=%0d score=%0d", pos, score, m_pos, m_score);
            end
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL walk_timeout got lives=%0d exp=1", lives); end
        total++;
        if ({state, pos, dir, lives, score} !== {2'd1, 4'd7, 2'd0, 2'd1, 16'd5}) begin
            bad++; $display("FAIL walk_respawn got st=%0d pos=%0d dir=%0d lives=%0d score=%0d exp 1/7/0/1/5",
                            state, pos, dir, lives, score);
        end
        total++;
        if (maxp !== 12) begin bad++; $display("FAIL walk_maxpos got=%0d exp=12", maxp); end
    endtask

    task automatic test_lose();
        int n = 0;
        drive(0, 1, 0, 0, 0);
        while (state != 2'd2 && n < 200) begin drive(0, 0, 0, 0, 0); n++; end
        total++;
        if ({state, lives, led} !== {2'd2, 2'd0, 16'hFFFF}) begin
            bad++; $display("FAIL lose_entry got st=%0d lives=%0d led=%h exp 2/0/ffff", state, lives, led);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, 0);
            total++;
            if (led !== (((k / BK) % 2 == 0) ? 16'hFFFF : 16'h0000) || led !== model_led()) begin
                bad++; $display("FAIL lose_blink k=%0d got=%h exp=%h", k, led, model_led());
            end
        end
        drive(1, 0, 0, 0, 0);
        total++;
        if ({state, lives, score, led} !== {2'd0, 2'd2, 16'd0, model_led()}) begin
            bad++; $display("FAIL lose_exit got st=%0d lives=%0d score=%0d led=%h exp 0/2/0/%h",
                            state, lives, score, led, model_led());
        end
    endtask

    task automatic test_speed();
        int n = 0;
        repeat (5) drive(0, 0, 0, 1, 0);
        total++;
        if (speed !== 2'd3) begin bad++; $display("FAIL speed_sat got=%0d exp=3", speed); end
        drive(0, 0, 0, 1, 1);
        total++;
        if (speed !== 2'd3) begin bad++; $display("FAIL speed_both got=%0d exp=3", speed); end
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0);
            total++;
            if (pos !== 4'(7 + k)) begin bad++; $display("FAIL speed_step got=%0d exp=%0d", pos, 7 + k); end
        end
        while (state != 2'd2 && n < 100) begin drive(0, (lives == 2'd1 && dir == 2'd0), 0, 0, 0); n++; end
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL speed_lose got=%0d exp=2", state); end
        drive(0, 0, 0, 0, 1);
        total++;
        if (speed !== 2'd3) begin bad++; $display("FAIL speed_lose_ignored got=%0d exp=3", speed); end
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        lm_in = 4'd0; rm_in = 4'd0;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({state, pos, dir, speed, lives, score, led} !== {2'd0, 4'd7, 2'd0, 2'd0, 2'd2, 16'd0, 16'h81C1}) begin
            bad++; $display("FAIL async_reset got st=%0d pos=%0d dir=%0d spd=%0d lives=%0d score=%0d led=%h",
                            state, pos, dir, speed, lives, score, led);
        end
        #2 reset_n = 1'b1;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 0);
            total++;
            if ({state, pos, score} !== {2'(m_state), 4'(m_pos), 16'(m_score)}) begin
                bad++; $display("FAIL after_reset got st=%0d pos=%0d score=%0d exp %0d/%0d/%0d",
                                state, pos, score, m_state, m_pos, m_score);
            end
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int k = 0; k < 1500; k++) begin
            if (m_state == 0 && $urandom_range(0, 7) == 0) begin
                lm_in = 4'($urandom_range(0, 3)); rm_in = 4'($urandom_range(0, 3));
            end
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            total++;
            if ({state, pos, dir, speed, lives, score, led} !==
                {2'(m_state), 4'(m_pos), 2'(m_dir), 2'(m_speed), 2'(m_lives), 16'(m_score), model_led()}) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random k=%0d got st=%0d pos=%0d dir=%0d spd=%0d lives=%0d score=%0d led=%h exp %0d/%0d/%0d/%0d/%0d/%0d/%h",
                             k, state, pos, dir, speed, lives, score, led,
                             m_state, m_pos, m_dir, m_speed, m_lives, m_score, model_led());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_move();
        test_walk();
        test_lose();
        test_speed();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
